eth_rx_fcs_filter: RTL and testbench

Frame-qualification stage between the RMII receiver byte stream and the capture/DMA engine, all in the 50 MHz PHY clock domain. Checks the Ethernet FCS (CRC-32) on every frame, strips the 4 FCS bytes through a 4-byte delay line, enforces minimum and maximum length, and issues one status word per forwarded frame at end-of-packet. Optional saturating good/bad frame counters support link diagnostics.

---
 rtl/eth_pkg.sv | 30 +++
 rtl/eth_crc32_byte.sv | 20 ++
 rtl/eth_rx_fcs_filter.sv | 177 +++++++++++++++++
 tb/tb_eth_rx_fcs_filter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, RX status word and RX qualifier states.
package eth_pkg;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [11:0] ETH_LEN_SAT     = 12'hFFF;

  typedef struct packed {
    logic aborted;
    logic giant;
    logic runt;
    logic crc_ok;
  } eth_rx_status_t;

  localparam eth_rx_status_t ETH_STATUS_GOOD = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PASS,
    ST_DROP
  } eth_rx_state_t;

  // Frame length counter increment that sticks at the 12-bit ceiling.
  function automatic logic [11:0] eth_len_inc(input logic [11:0] len);
    return (len == ETH_LEN_SAT) ? len : len + 12'd1;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update for one byte, LSB first; shared by RX check and TX FCS.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_rx_fcs_filter.sv
// RX frame qualifier: checks FCS, strips it through a 4-byte delay line, enforces length limits.
// Saturating good/bad frame counters exist only when ETH_RX_FCS_FILTER_STATS_EN is defined.
module eth_rx_fcs_filter
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  input  logic        rxsop,
  input  logic        rxeop,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  output logic [3:0]  o_status,
  output logic [11:0] o_len,
  output logic [15:0] o_cnt_good,
  output logic [15:0] o_cnt_bad
);

  localparam logic [11:0] MAX_LEN_L = 12'(MAX_LEN);
  localparam logic [11:0] MIN_LEN_L = 12'(MIN_LEN);

  eth_rx_state_t   state_reg;
  logic [31:0]     crc_reg;
  logic [31:0]     crc_next;
  logic [11:0]     len_reg;
  logic [11:0]     len_next;
  logic [3:0][7:0] dly_reg;

  logic [7:0]      data_reg;
  logic            valid_reg;
  logic            sop_reg;
  logic            eop_reg;
  eth_rx_status_t  status_reg;
  logic [11:0]     len_out_reg;

  logic            in_frame;
  logic            eop_fire;
  eth_rx_status_t  eop_status;

  eth_crc32_byte u_crc (
    .crc      (crc_reg),
    .data     (rxdata),
    .crc_next (crc_next)
  );

  // End-of-frame is reported for rxeop (normal end) or rxsop (abort) once forwarding began.
  always_comb begin
    len_next           = eth_len_inc(len_reg);
    in_frame           = (state_reg == ST_PASS) || (state_reg == ST_DROP);
    eop_fire           = in_frame && (rxsop || rxeop);
    eop_status         = '0;
    eop_status.aborted = rxsop;
    eop_status.giant   = (state_reg == ST_DROP);
    eop_status.runt    = (len_reg < MIN_LEN_L);
    eop_status.crc_ok  = !rxsop && (crc_reg == ETH_CRC_RESIDUE);
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      crc_reg     <= ETH_CRC_INIT;
      len_reg     <= '0;
      dly_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      sop_reg     <= 1'b0;
      eop_reg     <= 1'b0;
      status_reg  <= '0;
      len_out_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;

      if (eop_fire) begin
        eop_reg     <= 1'b1;
        status_reg  <= eop_status;
        len_out_reg <= len_reg;
      end

      if (rxsop) begin
        state_reg <= ST_FILL;
        crc_reg   <= ETH_CRC_INIT;
        len_reg   <= '0;
        dly_reg   <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
          end
          ST_FILL: begin
            if (rxeop) begin
              state_reg <= ST_IDLE;
            end else if (rxvalid) begin
              crc_reg <= crc_next;
              len_reg <= len_next;
              dly_reg <= {dly_reg[2:0], rxdata};
              if (len_next == 12'd4) begin
                state_reg <= ST_PASS;
                sop_reg   <= 1'b1;
              end
            end
          end
          ST_PASS: begin
            if (rxeop) begin
              state_reg <= ST_IDLE;
            end else if (rxvalid) begin
              crc_reg <= crc_next;
              len_reg <= len_next;
              dly_reg <= {dly_reg[2:0], rxdata};
              if (len_next > MAX_LEN_L) begin
                state_reg <= ST_DROP;
              end else begin
                valid_reg <= 1'b1;
                data_reg  <= dly_reg[3];
              end
            end
          end
          ST_DROP: begin
            if (rxeop) begin
              state_reg <= ST_IDLE;
            end else if (rxvalid) begin
              crc_reg <= crc_next;
              len_reg <= len_next;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_data   = data_reg;
  assign o_valid  = valid_reg;
  assign o_sop    = sop_reg;
  assign o_eop    = eop_reg;
  assign o_status = status_reg;
  assign o_len    = len_out_reg;

`ifdef ETH_RX_FCS_FILTER_STATS_EN
  logic [15:0] cnt_good_reg;
  logic [15:0] cnt_bad_reg;
  logic        good_evt;
  logic        bad_evt;

  // Frames that end while still filling never reach o_eop but still count as bad.
  assign good_evt = eop_fire && (eop_status == ETH_STATUS_GOOD);
  assign bad_evt  = (eop_fire && (eop_status != ETH_STATUS_GOOD)) ||
                    ((state_reg == ST_FILL) && (rxsop || rxeop));

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      cnt_good_reg <= '0;
      cnt_bad_reg  <= '0;
    end else begin
      if (good_evt && (cnt_good_reg != 16'hFFFF)) begin
        cnt_good_reg <= cnt_good_reg + 16'd1;
      end
      if (bad_evt && (cnt_bad_reg != 16'hFFFF)) begin
        cnt_bad_reg <= cnt_bad_reg + 16'd1;
      end
    end
  end

  assign o_cnt_good = cnt_good_reg;
  assign o_cnt_bad  = cnt_bad_reg;
`else
  assign o_cnt_good = '0;
  assign o_cnt_bad  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_filter.sv
// Directed self-checking bench for eth_rx_fcs_filter; counter expectations follow
// whether ETH_RX_FCS_FILTER_STATS_EN is defined.
module tb_eth_rx_fcs_filter;

`ifdef ETH_RX_FCS_FILTER_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk50   = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rxdata  = '0;
  logic        rxvalid = 1'b0;
  logic        rxsop   = 1'b0;
  logic        rxeop   = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_sop;
  logic        o_eop;
  logic [3:0]  o_status;
  logic [11:0] o_len;
  logic [15:0] o_cnt_good;
  logic [15:0] o_cnt_bad;

  int checks   = 0;
  int errors   = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  logic [7:0]  frm[$];
  logic [7:0]  rx_q[$];
  logic [3:0]  st_q[$];
  logic [11:0] len_q[$];
  int          sop_cnt   = 0;
  int          excl_err  = 0;
  int          order_err = 0;
  bit          sop_armed = 1'b0;

  always #10 clk50 = ~clk50;

  eth_rx_fcs_filter #(.MAX_LEN(1518), .MIN_LEN(64)) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .rxdata     (rxdata),
    .rxvalid    (rxvalid),
    .rxsop      (rxsop),
    .rxeop      (rxeop),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_status   (o_status),
    .o_len      (o_len),
    .o_cnt_good (o_cnt_good),
    .o_cnt_bad  (o_cnt_bad)
  );

  // Output monitor: records forwarded bytes and end-of-frame reports, tracks ordering.
  always @(negedge clk50) begin
    if ((int'(o_sop === 1'b1) + int'(o_valid === 1'b1) + int'(o_eop === 1'b1)) > 1) excl_err++;
    if (o_valid === 1'b1) begin
      rx_q.push_back(o_data);
      if (!sop_armed) order_err++;
    end
    if (o_sop === 1'b1) begin
      sop_cnt++;
      sop_armed = 1'b1;
    end
    if (o_eop === 1'b1) begin
      st_q.push_back(o_status);
      len_q.push_back(o_len);
      sop_armed = 1'b0;
    end
  end

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[i]}});
    return r;
  endfunction

  function automatic void append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = crc_model(c, frm[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endfunction

  function automatic void zero_frame();
    frm.delete();
    repeat (60) frm.push_back(8'h00);
    append_fcs();
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
    return STATS_EN ? 16'(n) : 16'd0;
  endfunction

  function automatic logic [3:0] status_at(input int i);
    return (i < st_q.size()) ? st_q[i] : 4'bxxxx;
  endfunction

  function automatic logic [11:0] len_at(input int i);
    return (i < len_q.size()) ? len_q[i] : 12'bx;
  endfunction

  function automatic void clear_mon();
    rx_q.delete();
    st_q.delete();
    len_q.delete();
    sop_cnt   = 0;
    sop_armed = 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic pulse_sop();
    @(negedge clk50); rxsop = 1'b1;
    @(negedge clk50); rxsop = 1'b0;
    tick(2);
  endtask

  task automatic pulse_eop();
    @(negedge clk50); rxeop = 1'b1;
    @(negedge clk50); rxeop = 1'b0;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk50); rxdata = b; rxvalid = 1'b1;
    @(negedge clk50); rxvalid = 1'b0;
    tick(2);
  endtask

  task automatic send_body();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic send_frame();
    pulse_sop();
    send_body();
    pulse_eop();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(4);
    checks++;
    if ({o_sop, o_valid, o_eop} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {o_sop, o_valid, o_eop});
    end
    checks++;
    if ({o_data, o_status, o_len} !== 24'd0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h want 0", o_data, o_status, o_len);
    end
    checks++;
    if ({o_cnt_good, o_cnt_bad} !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %h/%h want 0", o_cnt_good, o_cnt_bad);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_check_value();
    logic [7:0] want;
    clear_mon();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame();
    exp_bad++;
    checks++;
    if (sop_cnt !== 1) begin errors++; $display("FAIL cv_sop got %0d want 1", sop_cnt); end
    checks++;
    if (rx_q.size() !== 9) begin errors++; $display("FAIL cv_count got %0d want 9", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 9; i++) begin
      want = 8'h31 + 8'(i);
      checks++;
      if (rx_q[i] !== want) begin
        errors++; $display("FAIL cv_byte%0d got %h want %h", i, rx_q[i], want);
      end
    end
    checks++;
    if (st_q.size() !== 1 || status_at(0) !== 4'b0011) begin
      errors++; $display("FAIL cv_status got %b (n=%0d) want 0011", status_at(0), st_q.size());
    end
    checks++;
    if (len_at(0) !== 12'd13) begin errors++; $display("FAIL cv_len got %0d want 13", len_at(0)); end
    checks++;
    if (o_cnt_bad !== exp_cnt(exp_bad)) begin
      errors++; $display("FAIL cv_cnt_bad got %0d want %0d", o_cnt_bad, exp_cnt(exp_bad));
    end
    checks++;
    if (o_cnt_good !== exp_cnt(exp_good)) begin
      errors++; $display("FAIL cv_cnt_good got %0d want %0d", o_cnt_good, exp_cnt(exp_good));
    end
  endtask

  task automatic test_good_frame();
    int nz;
    clear_mon();
    zero_frame();
    send_frame();
    exp_good++;
    nz = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'h00) nz++;
    checks++;
    if (sop_cnt !== 1) begin errors++; $display("FAIL good_sop got %0d want 1", sop_cnt); end
    checks++;
    if (rx_q.size() !== 60 || nz != 0) begin
      errors++; $display("FAIL good_payload got %0d bytes (%0d nonzero) want 60 zero", rx_q.size(), nz);
    end
    checks++;
    if (st_q.size() !== 1 || status_at(0) !== 4'b0001) begin
      errors++; $display("FAIL good_status got %b want 0001", status_at(0));
    end
    checks++;
    if (len_at(0) !== 12'd64) begin errors++; $display("FAIL good_len got %0d want 64", len_at(0)); end
    checks++;
    if (o_cnt_good !== exp_cnt(exp_good)) begin
      errors++; $display("FAIL good_cnt_good got %0d want %0d", o_cnt_good, exp_cnt(exp_good));
    end
  endtask

  task automatic test_bad_fcs();
    clear_mon();
    zero_frame();
    frm[63] = frm[63] ^ 8'hFF;
    send_frame();
    exp_bad++;
    checks++;
    if (st_q.size() !== 1 || status_at(0) !== 4'b0000) begin
      errors++; $display("FAIL badfcs_status got %b want 0000", status_at(0));
    end
    checks++;
    if (len_at(0) !== 12'd64) begin errors++; $display("FAIL badfcs_len got %0d want 64", len_at(0)); end
    checks++;
    if (o_cnt_bad !== exp_cnt(exp_bad)) begin
      errors++; $display("FAIL badfcs_cnt_bad got %0d want %0d", o_cnt_bad, exp_cnt(exp_bad));
    end
  endtask

  task automatic test_giant();
    int diff;
    clear_mon();
    frm.delete();
    for (int i = 0; i < 1596; i++) frm.push_back(8'(i * 7 + 3));
    append_fcs();
    send_frame();
    exp_bad++;
    checks++;
    if (rx_q.size() !== 1514) begin
      errors++; $display("FAIL giant_count got %0d want 1514", rx_q.size());
    end
    diff = 0;
    for (int i = 0; i < rx_q.size() && i < 1514; i++) if (rx_q[i] !== frm[i]) diff++;
    checks++;
    if (diff != 0) begin errors++; $display("FAIL giant_payload got %0d wrong bytes want 0", diff); end
    checks++;
    if (st_q.size() !== 1 || status_at(0) !== 4'b0101) begin
      errors++; $display("FAIL giant_status got %b want 0101", status_at(0));
    end
    checks++;
    if (len_at(0) !== 12'd1600) begin errors++; $display("FAIL giant_len got %0d want 1600", len_at(0)); end
    checks++;
    if (o_cnt_bad !== exp_cnt(exp_bad)) begin
      errors++; $display("FAIL giant_cnt_bad got %0d want %0d", o_cnt_bad, exp_cnt(exp_bad));
    end
  endtask

  task automatic test_abort();
    int diff;
    clear_mon();
    pulse_sop();
    frm.delete();
    for (int i = 1; i <= 20; i++) frm.push_back(8'(i));
    send_body();
    zero_frame();
    send_frame();
    exp_bad++;
    exp_good++;
    checks++;
    if (st_q.size() !== 2) begin errors++; $display("FAIL abort_eops got %0d want 2", st_q.size()); end
    checks++;
    if ((status_at(0) & 4'b1001) !== 4'b1000) begin
      errors++; $display("FAIL abort_status got %b want 1xx0", status_at(0));
    end
    checks++;
    if (len_at(0) !== 12'd20) begin errors++; $display("FAIL abort_len got %0d want 20", len_at(0)); end
    diff = 0;
    for (int i = 0; i < rx_q.size() && i < 16; i++) if (rx_q[i] !== 8'(i + 1)) diff++;
    checks++;
    if (rx_q.size() !== 76 || diff != 0) begin
      errors++; $display("FAIL abort_payload got %0d bytes (%0d wrong) want 76", rx_q.size(), diff);
    end
    checks++;
    if (status_at(1) !== 4'b0001 || len_at(1) !== 12'd64) begin
      errors++; $display("FAIL abort_next got %b/%0d want 0001/64", status_at(1), len_at(1));
    end
    checks++;
    if (sop_cnt !== 2) begin errors++; $display("FAIL abort_sop got %0d want 2", sop_cnt); end
    checks++;
    if (o_cnt_good !== exp_cnt(exp_good) || o_cnt_bad !== exp_cnt(exp_bad)) begin
      errors++; $display("FAIL abort_counters got %0d/%0d want %0d/%0d",
                         o_cnt_good, o_cnt_bad, exp_cnt(exp_good), exp_cnt(exp_bad));
    end
  endtask

  task automatic test_fill_drop();
    clear_mon();
    pulse_sop();
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    pulse_eop();
    exp_bad++;
    checks++;
    if (sop_cnt !== 0 || rx_q.size() !== 0 || st_q.size() !== 0) begin
      errors++; $display("FAIL short_silent got sop=%0d val=%0d eop=%0d want 0/0/0",
                         sop_cnt, rx_q.size(), st_q.size());
    end
    checks++;
    if (o_cnt_bad !== exp_cnt(exp_bad)) begin
      errors++; $display("FAIL short_cnt_bad got %0d want %0d", o_cnt_bad, exp_cnt(exp_bad));
    end
  endtask

  task automatic test_fill_restart();
    clear_mon();
    pulse_sop();
    send_byte(8'h55);
    send_byte(8'h66);
    zero_frame();
    send_frame();
    exp_bad++;
    exp_good++;
    checks++;
    if (st_q.size() !== 1 || status_at(0) !== 4'b0001 || rx_q.size() !== 60 || sop_cnt !== 1) begin
      errors++; $display("FAIL restart_frame got eops=%0d st=%b bytes=%0d sop=%0d want 1/0001/60/1",
                         st_q.size(), status_at(0), rx_q.size(), sop_cnt);
    end
    checks++;
    if (o_cnt_good !== exp_cnt(exp_good) || o_cnt_bad !== exp_cnt(exp_bad)) begin
      errors++; $display("FAIL restart_counters got %0d/%0d want %0d/%0d",
                         o_cnt_good, o_cnt_bad, exp_cnt(exp_good), exp_cnt(exp_bad));
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    pulse_sop();
    for (int i = 0; i < 10; i++) send_byte(8'(8'hC0 + i));
    @(negedge clk50); reset_n = 1'b0;
    tick(1);
    clear_mon();
    tick(3);
    exp_good = 0;
    exp_bad  = 0;
    checks++;
    if ({o_sop, o_valid, o_eop, o_data, o_status, o_len, o_cnt_good, o_cnt_bad} !== 59'd0) begin
      errors++; $display("FAIL midreset_outputs got %b%b%b %h %h %h %h %h want all 0",
                         o_sop, o_valid, o_eop, o_data, o_status, o_len, o_cnt_good, o_cnt_bad);
    end
    reset_n = 1'b1;
    tick(2);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_eop();
    checks++;
    if (st_q.size() !== 0 || rx_q.size() !== 0 || sop_cnt !== 0) begin
      errors++; $display("FAIL midreset_silent got eops=%0d bytes=%0d sop=%0d want 0/0/0",
                         st_q.size(), rx_q.size(), sop_cnt);
    end
    zero_frame();
    send_frame();
    exp_good++;
    checks++;
    if (st_q.size() !== 1 || status_at(0) !== 4'b0001) begin
      errors++; $display("FAIL midreset_recover got %b want 0001", status_at(0));
    end
    checks++;
    if (o_cnt_good !== exp_cnt(exp_good) || o_cnt_bad !== exp_cnt(exp_bad)) begin
      errors++; $display("FAIL midreset_counters got %0d/%0d want %0d/%0d",
                         o_cnt_good, o_cnt_bad, exp_cnt(exp_good), exp_cnt(exp_bad));
    end
  endtask

  task automatic test_ordering();
    checks++;
    if (excl_err != 0) begin errors++; $display("FAIL strobe_exclusive got %0d overlaps want 0", excl_err); end
    checks++;
    if (order_err != 0) begin errors++; $display("FAIL sop_before_valid got %0d violations want 0", order_err); end
  endtask

  initial begin
    test_reset();
    test_check_value();
    test_good_frame();
    test_bad_fcs();
    test_giant();
    test_abort();
    test_fill_drop();
    test_fill_restart();
    test_reset_mid_frame();
    test_ordering();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
